// File: rtl/hwag_ign_channel.sv
// Ignition coil channel: charges the coil at the set angle and sparks at the fire angle.
// Optional dwell limit enabled by defining HWAG_IGN_DWELL_LIMIT_EN.
module hwag_ign_channel #(
  parameter int unsigned ANGLE_W = 24,
  parameter int unsigned TIME_W  = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [ANGLE_W-1:0] acnt,
  input  logic [ANGLE_W-1:0] set_angle,
  input  logic [ANGLE_W-1:0] fire_angle,
  input  logic               upd,
  input  logic [TIME_W-1:0]  max_dwell,
  input  logic               flag_clr,
  output logic               out,
  output logic               fire,
  output logic               miss,
  output logic               dwell_ovf,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StArmed  = 2'd1,
    StCharge = 2'd2,
    StFire   = 2'd3
  } state_e;

  state_e             state_q;
  logic [ANGLE_W-1:0] acnt_q;
  logic [ANGLE_W-1:0] set_sh_q, fire_sh_q;
  logic [ANGLE_W-1:0] set_act_q, fire_act_q;
  logic               pend_q;
  logic               out_q, fire_q, miss_q;

  logic set_match, fire_match;
  logic charge_go, xfer, miss_set, dwell_hit;

  assign set_match  = (acnt_q == set_act_q);
  assign fire_match = (acnt_q == fire_act_q);

  // Equal set/fire angles would mean zero dwell, so charging is suppressed and miss wins.
  assign charge_go = ena && (state_q == StArmed) && set_match && !fire_match;
  assign miss_set  = ena && (state_q == StArmed) && fire_match;

  // Angles swap only while not charging, so a spark never uses a torn set/fire pair.
  assign xfer = pend_q && ((state_q == StIdle) || (state_q == StArmed)) && !charge_go;

`ifdef HWAG_IGN_DWELL_LIMIT_EN
  logic [TIME_W-1:0] timer_q;
  logic              dwell_ovf_q;

  assign dwell_hit = (max_dwell != '0) && (timer_q == max_dwell - TIME_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_q <= '0;
    end else if (charge_go) begin
      timer_q <= '0;
    end else if ((state_q == StCharge) && (timer_q != '1)) begin
      timer_q <= timer_q + TIME_W'(1);
    end
  end

  // A real fire-angle match on the same clk is a normal spark, not an overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwell_ovf_q <= 1'b0;
    end else if (ena && (state_q == StCharge) && !fire_match && dwell_hit) begin
      dwell_ovf_q <= 1'b1;
    end else if (flag_clr) begin
      dwell_ovf_q <= 1'b0;
    end
  end

  assign dwell_ovf = dwell_ovf_q;
`else
  logic unused_max_dwell;

  assign unused_max_dwell = ^max_dwell;
  assign dwell_hit        = 1'b0;
  assign dwell_ovf        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      acnt_q     <= '0;
      set_sh_q   <= '0;
      fire_sh_q  <= '0;
      set_act_q  <= '0;
      fire_act_q <= '0;
      pend_q     <= 1'b0;
      out_q      <= 1'b0;
      fire_q     <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      acnt_q <= acnt;

      if (upd) begin
        set_sh_q  <= set_angle;
        fire_sh_q <= fire_angle;
      end

      if (upd) begin
        pend_q <= 1'b1;
      end else if (xfer) begin
        pend_q <= 1'b0;
      end

      if (xfer) begin
        set_act_q  <= set_sh_q;
        fire_act_q <= fire_sh_q;
      end

      if (miss_set) begin
        miss_q <= 1'b1;
      end else if (flag_clr) begin
        miss_q <= 1'b0;
      end

      fire_q <= 1'b0;
      if (!ena) begin
        state_q <= StIdle;
        out_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            state_q <= StArmed;
            out_q   <= 1'b0;
          end
          StArmed: begin
            if (charge_go) begin
              state_q <= StCharge;
              out_q   <= 1'b1;
            end
          end
          StCharge: begin
            if (fire_match || dwell_hit) begin
              state_q <= StFire;
              out_q   <= 1'b0;
              fire_q  <= 1'b1;
            end
          end
          StFire: begin
            state_q <= StArmed;
            out_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out   = out_q;
  assign fire  = fire_q;
  assign miss  = miss_q;
  assign state = state_q;

endmodule
